// File: rtl/matrix_frame_controller.sv
// 8x8 LED matrix sequencer: double-buffered frame store, row scan with blanking, 16-level PWM.
// Row/col decode purely from registers; bank swaps land only on the last cycle of row 7.
module matrix_frame_controller #(
  parameter int ROW_PERIOD   = 27000,
  parameter int BLANK_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [2:0] wr_row,
  input  logic [7:0] wr_data,
  input  logic       swap_req,
  output logic       swap_done,
  input  logic [3:0] brightness,
  output logic       frame_start,
  output logic [7:0] row,
  output logic [7:0] col
);

  localparam int SW = $clog2(ROW_PERIOD);
  localparam logic [SW-1:0] SLOT_LAST = SW'(ROW_PERIOD - 1);
  localparam logic [SW-1:0] SLOT_BLANK = SW'(BLANK_CYCLES);

  logic [SW-1:0] slot_cnt_q, slot_cnt_d, slot_nxt;
  logic [2:0]    row_idx_q, row_idx_d;
  logic          front_sel_q, front_sel_d;
  logic          swap_pending_q, swap_pending_d;
  logic [3:0]    pwm_cnt_q, pwm_cnt_d;
  logic [3:0]    brightness_q, brightness_d;
  logic          swap_done_q, swap_done_d;
  logic          frame_start_q, frame_start_d;
  logic [7:0]    bank_q [2][8];
  logic [7:0]    bank_d [2][8];
  logic          slot_wrap, boundary, active;

  always_comb begin
    slot_wrap      = (slot_cnt_q == SLOT_LAST);
    boundary       = slot_wrap && (row_idx_q == 3'd7);
    slot_nxt       = slot_wrap ? '0 : slot_cnt_q + 1'b1;
    slot_cnt_d     = slot_nxt;
    row_idx_d      = slot_wrap ? row_idx_q + 3'd1 : row_idx_q;
    // pwm restarts at 0 on the first unblanked cycle of every slot
    pwm_cnt_d      = (slot_nxt <= SLOT_BLANK) ? 4'd0 : pwm_cnt_q + 4'd1;
    brightness_d   = boundary ? brightness : brightness_q;
    frame_start_d  = boundary;
    swap_done_d    = boundary && swap_pending_q;
    front_sel_d    = front_sel_q;
    swap_pending_d = swap_pending_q;
    if (boundary && swap_pending_q) begin
      front_sel_d    = ~front_sel_q;
      swap_pending_d = 1'b0;
    end else if (swap_req && !swap_pending_q) begin
      swap_pending_d = 1'b1;
    end
    bank_d = bank_q;
    if (wr_valid && !swap_pending_q) begin
      bank_d[~front_sel_q][wr_row] = wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt_q     <= '0;
      row_idx_q      <= 3'd0;
      front_sel_q    <= 1'b0;
      swap_pending_q <= 1'b0;
      pwm_cnt_q      <= 4'd0;
      brightness_q   <= 4'd0;
      swap_done_q    <= 1'b0;
      frame_start_q  <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < 8; r++) begin
          bank_q[b][r] <= 8'h00;
        end
      end
    end else begin
      slot_cnt_q     <= slot_cnt_d;
      row_idx_q      <= row_idx_d;
      front_sel_q    <= front_sel_d;
      swap_pending_q <= swap_pending_d;
      pwm_cnt_q      <= pwm_cnt_d;
      brightness_q   <= brightness_d;
      swap_done_q    <= swap_done_d;
      frame_start_q  <= frame_start_d;
      bank_q         <= bank_d;
    end
  end

  always_comb begin
    active      = (slot_cnt_q >= SLOT_BLANK);
    row         = active ? (8'b1 << row_idx_q) : 8'h00;
    col         = (active && (pwm_cnt_q < brightness_q)) ? bank_q[front_sel_q][row_idx_q] : 8'h00;
    wr_ready    = !swap_pending_q;
    swap_done   = swap_done_q;
    frame_start = frame_start_q;
  end

endmodule

// File: tb/tb_matrix_frame_controller.sv
// Directed bench for matrix_frame_controller with a cycle-level reference of scan, PWM and swap behaviour.
module tb_matrix_frame_controller;
  localparam int RP = 32;
  localparam int BL = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [2:0] wr_row = 3'd0;
  logic [7:0] wr_data = 8'h00;
  logic       swap_req = 1'b0;
  logic       swap_done;
  logic [3:0] brightness = 4'd0;
  logic       frame_start;
  logic [7:0] row;
  logic [7:0] col;

  int checks = 0;
  int errors = 0;

  int         t;
  logic [7:0] m_bank [2][8];
  logic       m_front, m_pend, m_sd, m_fs;
  logic [3:0] m_bq;

  matrix_frame_controller #(.ROW_PERIOD(RP), .BLANK_CYCLES(BL)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_row(wr_row), .wr_data(wr_data), .swap_req(swap_req), .swap_done(swap_done),
    .brightness(brightness), .frame_start(frame_start), .row(row), .col(col)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    t = 0; m_front = 1'b0; m_pend = 1'b0; m_bq = 4'd0; m_sd = 1'b0; m_fs = 1'b0;
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < 8; r++)
        m_bank[b][r] = 8'h00;
  endtask

  // One clock: advance the reference with the inputs presented to this edge, then compare all outputs.
  task automatic step();
    int s, r;
    logic boundary;
    logic [7:0] erow, ecol;
    boundary = (t % 256 == 255);
    if (wr_valid && !m_pend) m_bank[!m_front][wr_row] = wr_data;
    m_sd = 1'b0; m_fs = 1'b0;
    if (boundary) begin
      m_bq = brightness; m_fs = 1'b1;
      if (m_pend) begin m_front = !m_front; m_pend = 1'b0; m_sd = 1'b1; end
      else if (swap_req) m_pend = 1'b1;
    end else if (swap_req && !m_pend) m_pend = 1'b1;
    @(posedge clk); #1;
    t++;
    s = t % RP; r = (t / RP) % 8;
    erow = (s < BL) ? 8'h00 : 8'(1 << r);
    ecol = (s >= BL && ((s - BL) % 16) < int'(m_bq)) ? m_bank[m_front][r] : 8'h00;
    chk("row", 16'(row), 16'(erow));
    chk("col", 16'(col), 16'(ecol));
    chk("wr_ready", 16'(wr_ready), 16'(!m_pend));
    chk("swap_done", 16'(swap_done), 16'(m_sd));
    chk("frame_start", 16'(frame_start), 16'(m_fs));
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic run_to_boundary();
    while (t % 256 != 255) step();
  endtask

  task automatic wait_swap(output int n);
    n = 0;
    while (!swap_done && n < 600) begin step(); n++; end
  endtask

  // Counts lit cycles over slots 1..19 of row 0 (3 blank + 16 active), starting at frame_start.
  task automatic measure(output int on);
    on = 0;
    repeat (19) begin step(); if (col != 8'h00) on++; end
  endtask

  initial begin
    int n, on, d;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_row", 16'(row), 16'h0);
    chk("rst_col", 16'(col), 16'h0);
    chk("rst_wr_ready", 16'(wr_ready), 16'h1);
    chk("rst_swap_done", 16'(swap_done), 16'h0);
    chk("rst_frame_start", 16'(frame_start), 16'h0);
    rst = 1'b0;

    // idle scan
    run(300);

    // write row 3 and swap mid-frame
    brightness = 4'd15;
    wr_valid = 1'b1; wr_row = 3'd3; wr_data = 8'hA5;
    step();
    wr_valid = 1'b0;
    run(20);
    swap_req = 1'b1; step(); swap_req = 1'b0;
    chk("s2_ready_low", 16'(wr_ready), 16'h0);
    wait_swap(n);
    chk("s2_swap_seen", 16'(swap_done), 16'h1);
    chk("s2_fs_with_sd", 16'(frame_start), 16'h1);
    run(96);
    on = 0;
    repeat (32) begin step(); if (col == 8'hA5) on++; end
    chk("s2_duty_a5", 16'(on), 16'd27);

    // brightness sweep on row 0 = 0xFF
    wr_valid = 1'b1; wr_row = 3'd0; wr_data = 8'hFF;
    step();
    wr_valid = 1'b0;
    brightness = 4'd0;
    swap_req = 1'b1; step(); swap_req = 1'b0;
    wait_swap(n);
    chk("s3_swap_seen", 16'(swap_done), 16'h1);
    measure(on);
    chk("s3_b0", 16'(on), 16'd0);
    brightness = 4'd1;
    run_to_boundary(); step();
    measure(on);
    chk("s3_b1", 16'(on), 16'd1);
    brightness = 4'd8;
    run_to_boundary(); step();
    measure(on);
    chk("s3_b8", 16'(on), 16'd8);

    // swap requested on the boundary cycle itself
    run_to_boundary();
    swap_req = 1'b1; step(); swap_req = 1'b0;
    chk("s4_no_swap", 16'(swap_done), 16'h0);
    chk("s4_fs", 16'(frame_start), 16'h1);
    wait_swap(n);
    chk("s4_delay", 16'(n), 16'd256);

    // back-pressure with streaming writes, then a second swap
    brightness = 4'd15;
    run(10);
    swap_req = 1'b1; step(); swap_req = 1'b0;
    d = 0;
    wr_valid = 1'b1;
    n = 0;
    while (!swap_done && n < 600) begin
      wr_row = d[2:0]; wr_data = 8'(d); d++;
      step(); n++;
    end
    chk("s5_swap_seen", 16'(swap_done), 16'h1);
    repeat (8) begin wr_row = d[2:0]; wr_data = 8'(d); d++; step(); end
    wr_valid = 1'b0;
    swap_req = 1'b1; step(); swap_req = 1'b0;
    wait_swap(n);
    chk("s5_swap2_seen", 16'(swap_done), 16'h1);
    run(256);

    // reset while a swap is pending
    swap_req = 1'b1; step(); swap_req = 1'b0;
    run(40);
    chk("s6_pending", 16'(wr_ready), 16'h0);
    rst = 1'b1;
    #2;
    chk("s6_row", 16'(row), 16'h0);
    chk("s6_col", 16'(col), 16'h0);
    chk("s6_wr_ready", 16'(wr_ready), 16'h1);
    chk("s6_swap_done", 16'(swap_done), 16'h0);
    chk("s6_frame_start", 16'(frame_start), 16'h0);
    #2;
    rst = 1'b0;
    model_reset();
    run(600);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/matrix_frame_controller.md
Name: matrix_frame_controller

Overview:
Sequencer for the 8x8 matrix LED. It owns a double-buffered frame store (front and back banks), scans the front bank row by row with a blanking gap between rows, and applies 16-level PWM brightness. Requesters write rows into the back bank through a valid/ready port. A requested bank swap completes only at a frame boundary, so a partially written frame is never shown. It sits between the display logic and the top-level anode/cathode pins, and replaces the free-running row timer.

Parameters:
ROW_PERIOD, 27000, clocks per row slot; legal range ROW_PERIOD >= 2.
BLANK_CYCLES, 64, clocks at the start of each row slot during which all outputs are dark; legal range 0 <= BLANK_CYCLES < ROW_PERIOD.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
wr_valid  in  1  write request
wr_ready  out  1  controller can accept a write
wr_row  in  3  target row index in the back bank
wr_data  in  8  row pixels; bit i = column i, 1 = lit
swap_req  in  1  request a front/back exchange at the next frame boundary
swap_done  out  1  one-cycle pulse in the cycle the banks exchange
brightness  in  4  0 = off, 15 = maximum; sampled once per frame
frame_start  out  1  one-cycle pulse on the first cycle of each row-0 slot after a swap check
row  out  8  one-hot active row
col  out  8  active columns for the current row

Behaviour:
- Reset (asynchronous):
  - slot_cnt = 0, row_idx = 0, front bank = bank 0, swap_pending = 0, pwm_cnt = 0, brightness_q = 0.
  - Both banks cleared to 0.
  - Outputs: row = 0, col = 0, wr_ready = 1, swap_done = 0, frame_start = 0.
- Slot timing:
  - slot_cnt counts 0 .. ROW_PERIOD-1, then wraps to 0.
  - On wrap, row_idx increments modulo 8.
  - Boundary cycle: slot_cnt == ROW_PERIOD-1 and row_idx == 7.
- Blanking:
  - While slot_cnt < BLANK_CYCLES: row = 0, col = 0, pwm_cnt held at 0.
  - Otherwise row = 1 << row_idx and pwm_cnt increments every clock (4-bit, wraps).
- PWM gating:
  - col = front[row_idx] when slot_cnt >= BLANK_CYCLES and pwm_cnt < brightness_q; otherwise col = 0.
  - brightness = 0 gives dark; brightness = 15 gives 15/16 duty.
- Output timing: row and col are decoded from state registers only, so an input change never reaches them in the same cycle.
- brightness_q is loaded from brightness in the cycle after each boundary cycle (the frame_start cycle). The first load after reset happens at the first boundary.
- Writes:
  - A transfer occurs when wr_valid && wr_ready.
  - back[wr_row] <= wr_data on that edge.
  - The front bank is never written.
- wr_ready = !swap_pending.
- swap_req handling:
  - swap_req sampled high while swap_pending = 0 sets swap_pending on the next edge.
  - A write accepted in the same cycle as swap_req completes normally.
  - swap_req while already pending is ignored (no queuing).
- Swap execution:
  - On a boundary cycle with swap_pending already 1, the front/back select toggles at the edge ending that cycle.
  - At the same edge, swap_pending clears and swap_done pulses for the following cycle.
  - wr_ready returns to 1 in that same following cycle.
  - A swap_req first sampled on the boundary cycle itself waits for the next boundary.
- No copy on swap: the new back bank holds the previous front contents.
- frame_start pulses in the cycle after every boundary cycle, whether or not a swap occurred. It coincides with swap_done when a swap occurs.
- Reset mid-frame or mid-swap: all state returns to reset values. Pending swaps and bank contents are lost.

Test Plan:
All scenarios use ROW_PERIOD=32, BLANK_CYCLES=4.

1. Reset check: after rst, hold swap_req=0 and wr_valid=0 for 300 cycles -> row/col stay 0 during each slot's first 4 cycles; row steps 0x01..0x80 every 32 cycles; col = 0 throughout; frame_start pulses every 256 cycles.
2. Write and swap: write row 3 = 0xA5 with brightness=15, pulse swap_req mid-frame -> wr_ready low until the boundary; swap_done and frame_start pulse together. In the next frame, row = 0x08 with col = 0xA5 for 15 of every 16 active cycles, col = 0 in the 16th.
3. Brightness sweep: brightness 0, 1, 8 on successive frames with front row 0 = 0xFF -> col high 0, 1, 8 cycles per 16 active cycles. Each change takes effect only from the following frame_start.
4. Boundary race: swap_req asserted exactly on a boundary cycle -> no swap at that boundary; swap_done occurs 256 cycles later.
5. Back-pressure: wr_valid held high with incrementing data while swap pending -> no writes land until swap_done. Then, with a second swap requested, only post-swap writes appear in the displayed frame.
6. Async reset mid-swap: assert rst while swap_pending = 1 -> wr_ready = 1, swap_done never pulses, row = col = 0 immediately, bank 0 displayed as all zeros.
